// File: rtl/risc5_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : risc5_muldiv_if
//  Description : Execute-stage handshake and operand/result bundle for the
//                iterative multiply/divide unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface risc5_muldiv_if #(
    parameter int W = 32
);
    logic         en;
    logic         run;
    logic         op;
    logic         sgn;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         stall;
    logic [W-1:0] z_lo;
    logic [W-1:0] z_hi;
    logic         dbz;

    modport master (output en, run, op, sgn, x, y,
                    input  stall, z_lo, z_hi, dbz);

    modport slave  (input  en, run, op, sgn, x, y,
                    output stall, z_lo, z_hi, dbz);
endinterface
`default_nettype wire

// File: rtl/risc5_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : risc5_muldiv
//  Description : Iterative signed/unsigned multiply and Euclidean divide,
//                retiring K bits per enabled cycle on a shared datapath.
//  Revision    : 1.0  initial release
// ============================================================================
module risc5_muldiv #(
    parameter int W = 32,
    parameter int K = 1
) (
    input  logic            clk,
    input  logic            rst,
    risc5_muldiv_if.slave   bus
);

    localparam int c_ITER = W / K;
    localparam int c_CW   = $clog2(c_ITER + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_ITER - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [c_CW-1:0] r_cnt;
    logic            r_op;
    logic            r_neg_q;
    logic            r_neg_x;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;
    logic [W-1:0]    r_z_lo;
    logic [W-1:0]    r_z_hi;
    logic            r_dbz;

    logic            w_x_neg;
    logic            w_y_neg;
    logic [W-1:0]    w_x_mag;
    logic [W-1:0]    w_y_mag;
    logic            w_y_zero;
    logic [W+K-1:0]  w_pp;
    logic [W+K-1:0]  w_hx;
    logic [W:0]      w_rem;
    logic [W-1:0]    w_quo;
    logic [W-1:0]    w_nx_hi;
    logic [W-1:0]    w_nx_lo;
    logic [2*W-1:0]  w_prod;
    logic [2*W-1:0]  w_prod_s;
    logic            w_fix;
    logic [W-1:0]    w_q1;
    logic [W-1:0]    w_r1;
    logic [W-1:0]    w_res_lo;
    logic [W-1:0]    w_res_hi;

    assign w_x_neg  = bus.sgn & bus.x[W-1];
    assign w_y_neg  = bus.sgn & bus.y[W-1];
    assign w_x_mag  = w_x_neg ? -bus.x : bus.x;
    assign w_y_mag  = w_y_neg ? -bus.y : bus.y;
    assign w_y_zero = (bus.y == '0);

    assign bus.stall = bus.run & (r_state != c_DONE);
    assign bus.z_lo  = r_z_lo;
    assign bus.z_hi  = r_z_hi;
    assign bus.dbz   = r_dbz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else if (bus.en) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.run) begin
                    w_next = (bus.op & w_y_zero) ? c_DONE : c_BUSY;
                end
            end
            c_BUSY: begin
                if (!bus.run) begin
                    w_next = c_IDLE;
                end else if (r_cnt == c_LAST) begin
                    w_next = c_DONE;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    // Multiply: shift-add K multiplier bits into the high half.
    // Divide: K restoring steps, quotient bits shifted into r_lo.
    always_comb begin
        w_pp  = (W+K)'(r_lo[K-1:0]) * (W+K)'(r_a);
        w_hx  = (W+K)'(r_hi) + w_pp;
        w_rem = {1'b0, r_hi};
        w_quo = r_lo;
        for (int i = 0; i < K; i++) begin
            w_rem = {w_rem[W-1:0], w_quo[W-1]};
            w_quo = {w_quo[W-2:0], 1'b0};
            if (w_rem >= {1'b0, r_a}) begin
                w_rem    = w_rem - {1'b0, r_a};
                w_quo[0] = 1'b1;
            end
        end
        if (r_op) begin
            w_nx_hi = w_rem[W-1:0];
            w_nx_lo = w_quo;
        end else begin
            w_nx_hi = w_hx[W+K-1:K];
            w_nx_lo = {w_hx[K-1:0], r_lo[W-1:K]};
        end
    end

    // Negative dividend with nonzero remainder: bump quotient magnitude and
    // reflect the remainder so it lands in [0, |y|).
    always_comb begin
        w_prod   = {w_nx_hi, w_nx_lo};
        w_prod_s = r_neg_q ? -w_prod : w_prod;
        w_fix    = r_neg_x & (w_nx_hi != '0);
        w_q1     = w_nx_lo + W'(w_fix);
        w_r1     = w_fix ? (r_a - w_nx_hi) : w_nx_hi;
        if (r_op) begin
            w_res_lo = r_neg_q ? -w_q1 : w_q1;
            w_res_hi = w_r1;
        end else begin
            w_res_lo = w_prod_s[W-1:0];
            w_res_hi = w_prod_s[2*W-1:W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_op    <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_x <= 1'b0;
            r_a     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_z_lo  <= '0;
            r_z_hi  <= '0;
            r_dbz   <= 1'b0;
        end else if (bus.en) begin
            case (r_state)
                c_IDLE: begin
                    if (bus.run) begin
                        r_cnt   <= '0;
                        r_op    <= bus.op;
                        r_neg_q <= w_x_neg ^ w_y_neg;
                        r_neg_x <= w_x_neg;
                        r_a     <= bus.op ? w_y_mag : w_x_mag;
                        r_lo    <= bus.op ? w_x_mag : w_y_mag;
                        r_hi    <= '0;
                        if (bus.op & w_y_zero) begin
                            r_z_lo <= '1;
                            r_z_hi <= bus.x;
                            r_dbz  <= 1'b1;
                        end
                    end
                end
                c_BUSY: begin
                    if (bus.run) begin
                        r_cnt <= r_cnt + c_CW'(1);
                        r_hi  <= w_nx_hi;
                        r_lo  <= w_nx_lo;
                        if (r_cnt == c_LAST) begin
                            r_z_lo <= w_res_lo;
                            r_z_hi <= w_res_hi;
                            r_dbz  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_risc5_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_risc5_muldiv
//  Description : Scoreboard bench for risc5_muldiv at K=1 and K=4.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_risc5_muldiv;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
        logic [31:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;
    int   c1 = 0;
    int   c4 = 0;
    exp_t q1[$];
    exp_t q4[$];
    string n1[$];
    string n4[$];
    exp_t e1, e4;
    string s1, s4;

    always #5 clk = ~clk;

    risc5_muldiv_if #(.W(32)) b1 ();
    risc5_muldiv_if #(.W(32)) b4 ();

    risc5_muldiv #(.W(32), .K(1)) u_k1 (.clk(clk), .rst(rst), .bus(b1));
    risc5_muldiv #(.W(32), .K(4)) u_k4 (.clk(clk), .rst(rst), .bus(b4));

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        else passed++;
    endtask

    task automatic issue(input int d, input logic op, input logic sgn,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] elo, input logic [31:0] ehi,
                         input logic edbz, input int est, input string nm,
                         input int frz = -1, input bit keep = 1'b0, input bit now = 1'b0);
        exp_t e;
        bit   seen;
        if (!now) begin
            @(posedge clk);
            #1;
        end
        e.lo = elo; e.hi = ehi; e.dbz = edbz; e.st = est;
        if (d == 1) begin
            q1.push_back(e); n1.push_back(nm);
            b1.op = op; b1.sgn = sgn; b1.x = x; b1.y = y; b1.run = 1'b1;
        end else begin
            q4.push_back(e); n4.push_back(nm);
            b4.op = op; b4.sgn = sgn; b4.x = x; b4.y = y; b4.run = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if ((d == 1) ? !b1.stall : !b4.stall) seen = 1'b1;
            #1;
            if (i == frz)     b1.en = 1'b0;
            if (i == frz + 5) b1.en = 1'b1;
        end
        if (!seen) begin
            total++;
            $display("FAIL %s_timeout: no result after 200 cycles, required one", nm);
        end
        if (!keep) begin
            if (d == 1) b1.run = 1'b0;
            else        b4.run = 1'b0;
        end
    endtask

    // Monitors: count the stall window and compare each DONE-cycle result.
    always @(negedge clk) begin
        if (rst || !b1.run) c1 = 0;
        else if (b1.stall) c1++;
        else begin
            if (q1.size() == 0) begin
                total++;
                $display("FAIL k1_unexpected_done: got a result, required none");
            end else begin
                e1 = q1.pop_front();
                s1 = n1.pop_front();
                chk({s1, "_lo"},    b1.z_lo, e1.lo);
                chk({s1, "_hi"},    b1.z_hi, e1.hi);
                chk({s1, "_dbz"},   b1.dbz,  e1.dbz);
                chk({s1, "_stall"}, c1,      e1.st);
            end
            c1 = 0;
        end
    end

    always @(negedge clk) begin
        if (rst || !b4.run) c4 = 0;
        else if (b4.stall) c4++;
        else begin
            if (q4.size() == 0) begin
                total++;
                $display("FAIL k4_unexpected_done: got a result, required none");
            end else begin
                e4 = q4.pop_front();
                s4 = n4.pop_front();
                chk({s4, "_lo"},    b4.z_lo, e4.lo);
                chk({s4, "_hi"},    b4.z_hi, e4.hi);
                chk({s4, "_dbz"},   b4.dbz,  e4.dbz);
                chk({s4, "_stall"}, c4,      e4.st);
            end
            c4 = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b1.en = 1'b1; b1.run = 1'b0; b1.op = 1'b0; b1.sgn = 1'b0; b1.x = '0; b1.y = '0;
        b4.en = 1'b1; b4.run = 1'b0; b4.op = 1'b0; b4.sgn = 1'b0; b4.x = '0; b4.y = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_z_lo",  b1.z_lo,  32'h0);
        chk("rst_z_hi",  b1.z_hi,  32'h0);
        chk("rst_dbz",   b1.dbz,   1'b0);
        chk("rst_stall", b1.stall, 1'b0);

        // K=4 datapath
        issue(4, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'h1, 1'b0, 9, "k4_mulu");
        issue(4, 1'b0, 1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0, 9, "k4_muls");
        issue(4, 1'b1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 9, "k4_divu");
        issue(4, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFC, 32'd1, 1'b0, 9, "k4_divs");
        issue(4, 1'b1, 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1, "k4_dbz");

        // K=1 datapath
        issue(1, 1'b0, 1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0, 33, "muls");
        issue(1, 1'b1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, "divu");
        issue(1, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFC, 32'd1, 1'b0, 33, "div_m7_2");
        issue(1, 1'b1, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd4, 32'd1, 1'b0, 33, "div_m7_m2");
        issue(1, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 33, "div_ovf");
        issue(1, 1'b1, 1'b1, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1'b1, 1, "dbz");
        issue(1, 1'b0, 1'b0, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0, 38, "freeze", 10);

        // Abort: run dropped mid-operation leaves the previous result intact
        @(posedge clk);
        #1 b1.op = 1'b0; b1.sgn = 1'b0; b1.x = 32'd3; b1.y = 32'd3; b1.run = 1'b1;
        repeat (10) @(negedge clk);
        #1 b1.run = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_z_lo",  b1.z_lo,  32'd42);
        chk("abort_z_hi",  b1.z_hi,  32'd0);
        chk("abort_stall", b1.stall, 1'b0);
        issue(1, 1'b0, 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 32'hFFFFFFFF, 1'b0, 33, "after_abort");

        // Reset mid-operation
        @(posedge clk);
        #1 b1.op = 1'b0; b1.sgn = 1'b0; b1.x = 32'd9; b1.y = 32'd9; b1.run = 1'b1;
        repeat (10) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        chk("midrst_z_lo",  b1.z_lo,  32'd0);
        chk("midrst_z_hi",  b1.z_hi,  32'd0);
        chk("midrst_dbz",   b1.dbz,   1'b0);
        chk("midrst_stall", b1.stall, 1'b1);
        b1.run = 1'b0;

        // Back-to-back issue with operands changed during the DONE cycle
        issue(1, 1'b0, 1'b0, 32'd2, 32'd3, 32'd6, 32'd0, 1'b0, 33, "b2b_1", -1, 1'b1);
        issue(1, 1'b0, 1'b0, 32'd4, 32'd5, 32'd20, 32'd0, 1'b0, 33, "b2b_2", -1, 1'b0, 1'b1);

        repeat (5) @(negedge clk);
        chk("k1_queue_empty", q1.size(), 0);
        chk("k4_queue_empty", q4.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/risc5_muldiv.md
Name: risc5_muldiv

Overview:
- Parametrised multi-cycle integer multiply/divide unit for the RISC5 execute stage.
- Replaces the separate fixed 32-bit multiplier and divider with one iterative datapath.
- Configurable width and bits retired per cycle; adds divide-by-zero signalling and clean back-to-back issue.
- Uses the core's run/stall handshake and freezes with the core's memory-wait enable.

Parameters:
W, 32, operand width in bits; even, 8..64
K, 1, bits retired per iteration; 1, 2 or 4; must divide W

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
en  input  1  advance enable (core drives ~memwait); en=0 freezes all state
run  input  1  operation request, held high by the core while the instruction is in execute
op  input  1  0 = multiply, 1 = divide
sgn  input  1  1 = signed (two's complement), 0 = unsigned
x  input  W  multiplicand / dividend
y  input  W  multiplier / divisor
stall  output  1  combinational; high while the result is not yet available
z_lo  output  W  product[W-1:0] or quotient
z_hi  output  W  product[2W-1:W] or remainder
dbz  output  1  divide-by-zero flag for the current result

Behaviour:
- States: IDLE, BUSY, DONE. Iteration counter is ceil(log2(W/K+1)) bits.
- Stall equation: stall = run & (state != DONE).
- Reset: rst wins over en. On reset: state=IDLE, counter=0, z_lo=0, z_hi=0, dbz=0. Reset during BUSY aborts the operation.
- Nothing changes in a cycle where en=0 and rst=0. The stall output still follows the equation above.
- IDLE:
  - If run=1, latch x, y, op and sgn, clear the counter, then go to BUSY. Operands are sampled only here.
  - Exception: op=1 with y=0 goes straight to DONE.
- BUSY:
  - Each enabled cycle retires K bits. After W/K iterations go to DONE.
  - If run drops in BUSY, abort to IDLE. Outputs stay unchanged.
- DONE:
  - Entered on the clock edge that loads z_lo, z_hi and dbz.
  - stall=0 for exactly this one cycle; the core advances on this edge.
  - Next state is IDLE unconditionally. If run is still high there, it is a new instruction and a new operation starts (back-to-back issue).
- Latency:
  - Normal operation: stall high for W/K+1 cycles (IDLE cycle plus W/K BUSY cycles), then one DONE cycle.
  - Divide by zero: stall high for 1 cycle.
- Outputs are registered. They hold their value until the next DONE load or reset.
- Multiply:
  - Exact 2W-bit product.
  - sgn=1: both operands signed. sgn=0: both unsigned.
  - Signed multiply uses magnitude iteration with a final conditional negate, or Booth; either is acceptable if results match.
- Divide, sgn=0: q = floor(x/y), r = x - q*y.
- Divide, sgn=1: Euclidean division.
  - Remainder satisfies 0 <= r < |y|, and q = (x - r)/y.
  - Example: -7/2 gives q=-4, r=1. -7/-2 gives q=4, r=1.
  - Overflow case x = -2^(W-1), y = -1: q = -2^(W-1) (wraps), r = 0, dbz=0.
- Divide by zero (op=1, y=0): z_lo = all ones, z_hi = x, dbz = 1. dbz is 0 for every other result.
- Fixed iteration count; no early termination, so latency is data-independent.

Test Plan:
- W=32, K=1, op=0, sgn=1, x=-3, y=5 -> stall high exactly 33 cycles; DONE gives z_lo=0xFFFFFFF1, z_hi=0xFFFFFFFF, dbz=0.
- W=32, K=4, op=0, sgn=0, x=0xFFFFFFFF, y=2 -> stall high 9 cycles; z_lo=0xFFFFFFFE, z_hi=0x00000001.
- W=32, K=1, op=1:
  - sgn=0, x=100, y=7 -> z_lo=14, z_hi=2.
  - sgn=1, x=-7, y=2 -> z_lo=0xFFFFFFFC, z_hi=1.
  - sgn=1, x=-7, y=-2 -> z_lo=4, z_hi=1.
  - sgn=1, x=0x80000000, y=-1 -> z_lo=0x80000000, z_hi=0.
- Divide by zero: op=1, x=0x1234, y=0 -> stall high 1 cycle; z_lo=0xFFFFFFFF, z_hi=0x1234, dbz=1. A following multiply clears dbz to 0.
- Freeze, abort and reset:
  - en=0 for 5 cycles mid-BUSY -> stall extends by exactly 5 cycles; result unchanged (6*7 gives z_lo=42).
  - rst mid-BUSY -> next cycle state IDLE, z_lo=z_hi=0, stall=run.
  - run dropped mid-BUSY -> IDLE, outputs unchanged.
- Back-to-back: run held high across two multiplies (2*3, then 4*5, operands changed in the DONE cycle) -> two separate stall windows of 33 cycles, each followed by one stall=0 cycle; z_lo=6 then 20.
